// File: rtl/cs_result_buffer.sv
// CS result buffer: warm-up qualifier, FWFT FIFO, sticky overflow.
// Optional running maximum on `peak` when CS_PEAK_EN is defined.
module cs_result_buffer #(
  parameter int DW     = 10,
  parameter int DEPTH  = 8,
  parameter int WARMUP = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DW-1:0]            y_in,
  input  logic                     flush,
  input  logic                     clr_ovf,
  output logic [DW-1:0]            out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic [DW-1:0]            peak
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(WARMUP + 1);

  typedef enum logic {
    WARM,
    RUN
  } st_e;

  st_e           st_q;
  logic [CW-1:0] wcnt_q;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic push, pop, full, acc, drop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q   <= WARM;
      wcnt_q <= '0;
    end else if (st_q == WARM) begin
      wcnt_q <= wcnt_q + CW'(1);
      if (wcnt_q == CW'(WARMUP - 1)) st_q <= RUN;
    end
  end

  assign push = (st_q == RUN);
  assign pop  = out_valid && out_ready;
  assign full = (level_q == LW'(DEPTH));
  // A full FIFO still accepts when the head leaves on the same edge.
  assign acc  = push && !flush && (!full || pop);
  assign drop = push && !flush && full && !pop;

  always_comb begin
    wptr_d  = wptr_q + AW'(acc);
    rptr_d  = rptr_q + AW'(pop);
    level_d = level_q + LW'(acc) - LW'(pop);
    ovf_d   = (ovf_q && !clr_ovf) || drop;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) mem_q[wptr_q] <= y_in;
  end

  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? mem_q[rptr_q] : '0;
  assign level     = level_q;
  assign ovf       = ovf_q;

`ifdef CS_PEAK_EN
  logic [DW-1:0] peak_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_q <= '0;
    end else if (flush) begin
      peak_q <= '0;
    end else if (acc && (y_in > peak_q)) begin
      peak_q <= y_in;
    end
  end

  assign peak = peak_q;
`else
  assign peak = '0;
`endif

endmodule

// File: tb/tb_cs_result_buffer.sv
// Self-checking bench for cs_result_buffer.
// Queue-based reference model plus directed and random phases.
module tb_cs_result_buffer;

  localparam int DW     = 10;
  localparam int DEPTH  = 8;
  localparam int WARMUP = 9;

  logic          clk = 0;
  logic          reset;
  logic [DW-1:0] y_in;
  logic          flush;
  logic          clr_ovf;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    level;
  logic          ovf;
  logic [DW-1:0] peak;

  cs_result_buffer #(.DW(DW), .DEPTH(DEPTH), .WARMUP(WARMUP)) dut (
    .clk(clk), .reset(reset), .y_in(y_in), .flush(flush),
    .clr_ovf(clr_ovf), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .ovf(ovf), .peak(peak)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int mq[$];
  int movf;
  int mpeak;
  int ecnt;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_peak();
`ifdef CS_PEAK_EN
    return mpeak;
`else
    return 0;
`endif
  endfunction

  task automatic cmp_model();
    chk("out_valid", int'(out_valid), (mq.size() != 0) ? 1 : 0);
    chk("out_data", int'(out_data), (mq.size() != 0) ? mq[0] : 0);
    chk("level", int'(level), mq.size());
    chk("ovf", int'(ovf), movf);
    chk("peak", int'(peak), exp_peak());
  endtask

  // Drive one cycle of inputs, advance the model, clock, compare.
  task automatic cyc(input int y, input bit rdy, input bit fl,
                     input bit clr);
    bit push, pop, drop;
    y_in = DW'(y); out_ready = rdy; flush = fl; clr_ovf = clr;
    push = (ecnt >= WARMUP);
    pop  = (mq.size() != 0) && rdy;
    drop = 0;
    if (fl) begin
      mq.delete();
      mpeak = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(y);
          if (y > mpeak) mpeak = y;
        end else begin
          drop = 1;
        end
      end
    end
    movf = ((movf != 0) && !clr) || drop ? 1 : 0;
    if (ecnt < 100000) ecnt++;
    @(posedge clk);
    @(negedge clk);
    cmp_model();
  endtask

  task automatic model_reset();
    mq.delete();
    movf = 0; mpeak = 0; ecnt = 0;
  endtask

  initial begin
    reset = 0; y_in = 0; flush = 0; clr_ovf = 0; out_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_peak", int'(peak), 0);
    reset = 1;

    // Warm-up with y_in = edge index.
    for (int i = 1; i <= 14; i++) begin
      cyc(i, 1, 0, 0);
      if (i == 9) chk("warm_valid9", int'(out_valid), 0);
      if (i == 10) chk("first_data", int'(out_data), 10);
      if (i == 11) chk("second_data", int'(out_data), 11);
      chk("warm_level_le1", (level <= 1) ? 1 : 0, 1);
    end

    // Fill and overflow.
    cyc(0, 1, 1, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(100 + i, 0, 0, 0);
      if (i == 7) chk("fill_level8", int'(level), 8);
      if (i == 7) chk("fill_ovf0", int'(ovf), 0);
      if (i == 8) chk("ovf_set", int'(ovf), 1);
    end
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", int'(out_data), 100 + i);
      cyc(0, 1, 0, 0);
    end

    // Full with simultaneous pop.
    cyc(0, 1, 1, 1);
    for (int i = 0; i < 8; i++) cyc(200 + i, 0, 0, 0);
    cyc(500, 1, 0, 0);
    chk("fullpop_level", int'(level), 8);
    chk("fullpop_ovf", int'(ovf), 0);
    for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0);
    chk("fullpop_last", int'(out_data), 500);

    // Flush and clear with level 5 and ovf set.
    for (int i = 0; i < 2; i++) cyc(1, 0, 0, 0);
    chk("ovf_for_flush", int'(ovf), 1);
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(30 + i, 0, 0, 0);
    chk("pre_flush_level", int'(level), 5);
    cyc(99, 1, 1, 1);
    chk("flush_level", int'(level), 0);
    chk("flush_valid", int'(out_valid), 0);
    chk("flush_ovf", int'(ovf), 0);
    cyc(42, 0, 0, 0);
    chk("post_flush_data", int'(out_data), 42);

    // Asynchronous reset mid-stream at level 3.
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(700 + i, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("pre_reset_ovf", int'(ovf), 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(710 + i, 0, 0, 0);
    chk("pre_reset_level", int'(level), 3);
    #2 reset = 0;
    #1;
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_level", int'(level), 0);
    chk("arst_ovf", int'(ovf), 0);
    chk("arst_peak", int'(peak), 0);
    model_reset();
    @(negedge clk);
    reset = 1;
    for (int i = 1; i <= 11; i++) begin
      cyc(i, 1, 0, 0);
      if (i == 9) chk("rewarm_valid9", int'(out_valid), 0);
      if (i == 10) chk("rewarm_data", int'(out_data), 10);
    end

    // Peak sequence.
    cyc(0, 1, 1, 0);
    cyc(300, 1, 0, 0);
    chk("peak_a", int'(peak), exp_peak());
`ifdef CS_PEAK_EN
    chk("peak_300", int'(peak), 300);
`endif
    cyc(1023, 1, 0, 0);
`ifdef CS_PEAK_EN
    chk("peak_1023", int'(peak), 1023);
`endif
    cyc(5, 1, 0, 0);
`ifdef CS_PEAK_EN
    chk("peak_hold", int'(peak), 1023);
`endif
    cyc(900, 1, 1, 0);
`ifdef CS_PEAK_EN
    chk("peak_flush", int'(peak), 0);
`endif
    cyc(7, 1, 0, 0);
`ifdef CS_PEAK_EN
    chk("peak_7", int'(peak), 7);
`else
    chk("peak_off", int'(peak), 0);
`endif

    // Randomised traffic, alternating ready bias to reach full often.
    for (int i = 0; i < 3000; i++) begin
      bit rdy;
      if ((i / 200) % 2 == 0) rdy = ($urandom_range(0, 3) != 0);
      else rdy = ($urandom_range(0, 3) == 0);
      cyc(int'($urandom_range(0, 1023)), rdy,
          ($urandom_range(0, 47) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cs_result_buffer.md
# cs_result_buffer

Downstream stage of the computational-system (CS) averager. It samples the 10-bit CS result `Y` every clock, discards results produced before the 9-sample window is filled, and queues qualified results in a small first-word-fall-through FIFO. A valid/ready handshake delivers the results to the host, and a sticky overflow flag records any result dropped while the FIFO was full.

## Interface
- `DW`, 10: result width, matching CS `Y`.
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `WARMUP`, 9: clock edges after reset before `y_in` is qualified (CS window length).
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-low reset. Asserted (0) clears all state immediately; release is synchronous to `clk` by the system.
- `y_in` input DW: CS result, sampled every rising edge.
- `flush` input 1: synchronous; empties the FIFO in the cycle it is high.
- `clr_ovf` input 1: synchronous clear of `ovf`.
- `out_data` output DW: FIFO head; 0 when empty.
- `out_valid` output 1: FIFO not empty.
- `out_ready` input 1: host accepts `out_data` when `out_valid && out_ready` at the edge.
- `level` output $clog2(DEPTH)+1: current FIFO occupancy.
- `ovf` output 1: sticky, set when a qualified result is dropped.
- `peak` output DW: maximum qualified result since reset or `flush`. Valid only with `CS_PEAK_EN`.

## Operation
- State machine has two states, WARM and RUN. Reset enters WARM with `wcnt`=0.
- WARM: `wcnt` increments at each edge. When `wcnt`==WARMUP-1 at an edge, the FSM moves to RUN. No pushes occur in WARM.
- RUN: every edge presents `y_in` for push. The FSM stays in RUN until reset; `flush` does not restart warm-up.
- Push is accepted if `level`<DEPTH, or if `level`==DEPTH and a pop happens in the same edge.
- Otherwise the push is dropped and `ovf` is set.
- Pop occurs when `out_valid && out_ready`.
- Simultaneous push and pop leave `level` unchanged; the data order is preserved.
- Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `level` is tracked separately to distinguish full from empty.
- `flush` has priority over push and pop in the same edge. Pointers and `level` go to 0, the in-flight push is discarded, and `ovf` is unchanged.
- `clr_ovf` and a drop in the same edge leave `ovf`=1 (set wins).
- Reset mid-operation discards all FIFO contents and returns the FSM to WARM.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `level`=0, `ovf`=0, `peak`=0, FSM=WARM, `wcnt`=0.
- Warm-up: the first push occurs at edge number WARMUP+1 after reset release. Edges 1..WARMUP are discarded.
- Latency: a value pushed at edge k appears on `out_data` with `out_valid`=1 after edge k, if the FIFO was empty.
- Throughput: one push and one pop per cycle.
- With `out_ready` held at 1, `level` stays ≤1 in RUN.
- `out_data` and `out_valid` change only on clock edges or reset; no combinational path from `out_ready` to them.
- `level` and `ovf` update at the same edge as the push, pop, or drop that changes them.

## Configuration
- `CS_PEAK_EN` defined:
  - A DW-bit register tracks the maximum of all accepted pushes.
  - Comparison is unsigned, `>`.
  - The register is cleared by reset and by `flush`.
  - If a push and `flush` fall in the same edge, the push is ignored for `peak`.
- `CS_PEAK_EN` undefined: `peak` is tied to 0 and no register is inferred.

## Test plan
- Warm-up:
  - Stimulus: release reset, drive `y_in`=edge index 1,2,3…, hold `out_ready`=1.
  - Required: `out_valid` stays 0 through edge 9. First `out_data`=10 after edge 10, then 11, 12… each cycle. `level`≤1.
- Fill and overflow:
  - Stimulus: after warm-up, `out_ready`=0, `y_in`=100..111 for 12 edges.
  - Required: `level`=8 after the 8th push and `ovf`=1 after the 9th.
  - Draining then yields 100..107 in order; 108..111 are lost.
- Full with simultaneous pop:
  - Stimulus: fill to `level`=8, then one edge with `out_ready`=1 and `y_in`=500.
  - Required: `level` stays 8, `ovf` stays 0, and 500 is the last entry drained.
- Flush and clear:
  - Stimulus: with `level`=5 and `ovf`=1, pulse `flush` and `clr_ovf` together, with a push pending.
  - Required: next cycle `level`=0, `out_valid`=0, `ovf`=0. Later pushes resume normally with no new warm-up.
- Asynchronous reset mid-stream:
  - Stimulus: assert `reset`=0 between edges while `level`=3.
  - Required: `out_valid`, `level`, `ovf` and `peak` go to 0 without waiting for a clock edge. After release, 9 edges are discarded again.
- Peak (with `CS_PEAK_EN`):
  - Stimulus: pushes 300, 1023, 5, then `flush`, then push 7.
  - Required: `peak` reads 300, 1023, 1023, 0, 7.
  - Without the macro, `peak` stays 0 throughout.
